// File: rtl/shift_reg_ctrl_pkg.sv
// Shared types and constants for the PISO shift-register sequencer.
// State encoding, legal WIDTH bounds and the bit-counter width helper.
package shift_reg_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   // Counter must index 0..w-1; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/shift_reg_dp.sv
// WIDTH-bit storage register: parallel load, one-bit shift toward the output end with zero fill, or hold.
// Output-end bit is visible one cycle after load/shift; load has priority over shift.
module shift_reg_dp #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] word,
   output logic             out_bit
);

   logic [WIDTH-1:0] sreg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sreg <= '0;
      end else if (load) begin
         sreg <= word;
      end else if (shift) begin
         if (MSB_FIRST)
            sreg <= {sreg[WIDTH-2:0], 1'b0};
         else
            sreg <= {1'b0, sreg[WIDTH-1:1]};
      end
   end

   assign out_bit = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

endmodule

// File: rtl/shift_reg_ctrl.sv
// Load/shift/hold sequencer for a PISO register: one word per handshake, WIDTH bits out, then a DONE pulse.
// First bit one cycle after accept; HOLD stalls shifting and masks SO_VALID/SO_LAST combinationally.
module shift_reg_ctrl
   import shift_reg_ctrl_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             CP,
   input  logic             RN,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] IN_DATA,
   input  logic             HOLD,
   output logic             SO,
   output logic             SO_VALID,
   output logic             SO_LAST,
   output logic             DONE,
   output logic             BUSY
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
      $error("shift_reg_ctrl: WIDTH out of range");
   end

   state_t        state;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          consume;
   logic          at_last;
   logic          out_bit;

   assign accept  = (state == ST_IDLE) && IN_VALID;
   assign consume = (state == ST_SHIFT) && !HOLD;
   assign at_last = (cnt == LAST_IDX);

   always_ff @(posedge CP) begin
      if (!RN) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (IN_VALID) begin
                  state <= ST_SHIFT;
                  cnt   <= '0;
               end
            end
            ST_SHIFT: begin
               // Leaving at the last index keeps the counter from wrapping.
               if (!HOLD) begin
                  if (at_last)
                     state <= ST_DONE;
                  else
                     cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   shift_reg_dp #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_dp (
      .clk     (CP),
      .rst_n   (RN),
      .load    (accept),
      .shift   (consume),
      .word    (IN_DATA),
      .out_bit (out_bit)
   );

   assign IN_READY = (state == ST_IDLE);
   assign BUSY     = (state != ST_IDLE);
   assign DONE     = (state == ST_DONE);
   assign SO       = out_bit;
   assign SO_VALID = consume;
   assign SO_LAST  = consume && at_last;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl: directed scenarios plus randomized words/HOLD against a bit-index reference model.
module tb_shift_reg_ctrl;

   localparam int W = 8;

   logic         CP = 1'b0;
   logic         RN;
   logic         in_valid, in_ready, hold, so, so_valid, so_last, done, busy;
   logic [W-1:0] in_data;
   logic         in_valid_l, in_ready_l, hold_l, so_l, so_valid_l, so_last_l, done_l, busy_l;
   logic [W-1:0] in_data_l;

   int n_cmp = 0;
   int n_err = 0;

   shift_reg_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
      .CP(CP), .RN(RN), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
      .HOLD(hold), .SO(so), .SO_VALID(so_valid), .SO_LAST(so_last), .DONE(done), .BUSY(busy)
   );

   shift_reg_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .CP(CP), .RN(RN), .IN_VALID(in_valid_l), .IN_READY(in_ready_l), .IN_DATA(in_data_l),
      .HOLD(hold_l), .SO(so_l), .SO_VALID(so_valid_l), .SO_LAST(so_last_l), .DONE(done_l), .BUSY(busy_l)
   );

   always #5 CP = ~CP;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Inputs are driven 1 time unit after the edge, outputs sampled 1 unit later.
   task automatic step();
      @(posedge CP);
      #1;
   endtask

   // Bit j of the serial sequence for word w, derived directly from the word.
   function automatic logic ref_bit(input logic [W-1:0] w, input int j, input bit msb);
      return msb ? w[W-1-j] : w[j];
   endfunction

   task automatic test_reset();
      logic [5:0] got;
      RN = 1'b0; in_valid = 1'b1; in_data = 8'hFF; hold = 1'b0;
      in_valid_l = 1'b1; in_data_l = 8'hFF; hold_l = 1'b0;
      repeat (2) step();
      #1;
      got = {in_ready, busy, so, so_valid, so_last, done};
      n_cmp++;
      if (got !== 6'b100000) begin
         n_err++; $display("FAIL reset_msb got %b want %b", got, 6'b100000);
      end
      got = {in_ready_l, busy_l, so_l, so_valid_l, so_last_l, done_l};
      n_cmp++;
      if (got !== 6'b100000) begin
         n_err++; $display("FAIL reset_lsb got %b want %b", got, 6'b100000);
      end
      RN = 1'b1; in_valid = 1'b0; in_valid_l = 1'b0;
      step();
      #1;
      got = {in_ready, busy, so_valid, done, in_ready_l, busy_l};
      n_cmp++;
      if (got !== 6'b100010) begin
         n_err++; $display("FAIL reset_no_capture got %b want %b", got, 6'b100010);
      end
   endtask

   task automatic test_msb_first(input logic [W-1:0] w);
      logic [4:0] got, exp;
      in_valid = 1'b1; in_data = w;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL msb_ready got %b want 1", in_ready);
      end
      step();
      in_valid = 1'b0; in_data = 8'($urandom);
      for (int i = 1; i <= W; i++) begin
         #1;
         got = {so, so_valid, so_last, done, in_ready};
         exp = {ref_bit(w, i-1, 1'b1), 1'b1, (i == W), 1'b0, 1'b0};
         n_cmp++;
         if (got !== exp) begin
            n_err++; $display("FAIL msb_bit%0d got %b want %b", i, got, exp);
         end
         step();
      end
      #1;
      n_cmp++;
      if ({so_valid, done, in_ready, busy} !== 4'b0101) begin
         n_err++; $display("FAIL msb_done got %b want 0101", {so_valid, done, in_ready, busy});
      end
      step();
      #1;
      n_cmp++;
      if ({done, in_ready, busy} !== 3'b010) begin
         n_err++; $display("FAIL msb_ready_again got %b want 010", {done, in_ready, busy});
      end
   endtask

   task automatic test_lsb_first();
      logic [W-1:0] w;
      logic [3:0]   got, exp;
      for (int n = 0; n < 4; n++) begin
         w = (n == 0) ? 8'h01 : 8'($urandom);
         in_valid_l = 1'b1; in_data_l = w;
         step();
         in_valid_l = 1'b0; in_data_l = 8'($urandom);
         for (int i = 1; i <= W; i++) begin
            #1;
            got = {so_l, so_valid_l, so_last_l, done_l};
            exp = {ref_bit(w, i-1, 1'b0), 1'b1, (i == W), 1'b0};
            n_cmp++;
            if (got !== exp) begin
               n_err++; $display("FAIL lsb_w%0d_bit%0d got %b want %b", n, i, got, exp);
            end
            step();
         end
         #1;
         n_cmp++;
         if ({done_l, so_valid_l} !== 2'b10) begin
            n_err++; $display("FAIL lsb_done got %b want 10", {done_l, so_valid_l});
         end
         step();
      end
   endtask

   task automatic test_hold();
      logic [W-1:0] w = 8'hA5;
      logic [3:0]   got, exp;
      int           j = 0;
      int           c = 1;
      in_valid = 1'b1; in_data = w;
      step();
      in_valid = 1'b0;
      while (j < W && c < 40) begin
         hold = (c >= 4 && c <= 6);
         #1;
         got = {so, so_valid, so_last, done};
         exp = {ref_bit(w, j, 1'b1), !hold, (!hold && j == W-1), 1'b0};
         n_cmp++;
         if (got !== exp) begin
            n_err++; $display("FAIL hold_cycle%0d got %b want %b", c, got, exp);
         end
         if (!hold) j++;
         step();
         c++;
      end
      hold = 1'b0;
      #1;
      n_cmp++;
      if ({done, so_valid, in_ready} !== 3'b100) begin
         n_err++; $display("FAIL hold_done_cycle%0d got %b want 100", c, {done, so_valid, in_ready});
      end
      step();
      #1;
      n_cmp++;
      if ({done, in_ready} !== 2'b01) begin
         n_err++; $display("FAIL hold_idle got %b want 01", {done, in_ready});
      end
   endtask

   task automatic test_busy_reject();
      logic [W-1:0] words [2];
      logic [4:0]   got, exp;
      words[0] = 8'hA5; words[1] = 8'h3C;
      in_valid = 1'b1; in_data = words[0];
      step();
      in_data = words[1];
      for (int n = 0; n < 2; n++) begin
         for (int i = 1; i <= W; i++) begin
            #1;
            got = {so, so_valid, so_last, done, in_ready};
            exp = {ref_bit(words[n], i-1, 1'b1), 1'b1, (i == W), 1'b0, 1'b0};
            n_cmp++;
            if (got !== exp) begin
               n_err++; $display("FAIL busy_w%0d_bit%0d got %b want %b", n, i, got, exp);
            end
            step();
         end
         #1;
         n_cmp++;
         if ({done, in_ready} !== 2'b10) begin
            n_err++; $display("FAIL busy_w%0d_done got %b want 10", n, {done, in_ready});
         end
         step();
         #1;
         n_cmp++;
         if ({busy, in_ready} !== 2'b01) begin
            n_err++; $display("FAIL busy_w%0d_idle got %b want 01", n, {busy, in_ready});
         end
         if (n == 0) begin
            step();
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] w = 8'h0F;
      logic [3:0]   got, exp;
      in_valid = 1'b1; in_data = 8'hA5;
      step();
      in_valid = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         #1;
         n_cmp++;
         if (so !== ref_bit(8'hA5, i-1, 1'b1)) begin
            n_err++; $display("FAIL rstmid_bit%0d got %b want %b", i, so, ref_bit(8'hA5, i-1, 1'b1));
         end
         if (i == 2) RN = 1'b0;
         step();
      end
      RN = 1'b1;
      #1;
      n_cmp++;
      if ({in_ready, busy, so, so_valid, done} !== 5'b10000) begin
         n_err++; $display("FAIL rstmid_abort got %b want 10000", {in_ready, busy, so, so_valid, done});
      end
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         n_cmp++;
         if ({done, busy} !== 2'b00) begin
            n_err++; $display("FAIL rstmid_no_done%0d got %b want 00", i, {done, busy});
         end
      end
      in_valid = 1'b1; in_data = w;
      step();
      in_valid = 1'b0;
      for (int i = 1; i <= W; i++) begin
         #1;
         got = {so, so_valid, so_last, done};
         exp = {ref_bit(w, i-1, 1'b1), 1'b1, (i == W), 1'b0};
         n_cmp++;
         if (got !== exp) begin
            n_err++; $display("FAIL rstmid_new_bit%0d got %b want %b", i, got, exp);
         end
         step();
      end
      #1;
      n_cmp++;
      if (done !== 1'b1) begin
         n_err++; $display("FAIL rstmid_new_done got %b want 1", done);
      end
      step();
   endtask

   task automatic test_random();
      logic [W-1:0] w;
      logic [3:0]   got, exp;
      int           j, c;
      for (int n = 0; n < 16; n++) begin
         in_valid = 1'b0; hold = 1'($urandom);
         #1;
         n_cmp++;
         if ({in_ready, busy, done} !== 3'b100) begin
            n_err++; $display("FAIL rand_w%0d_idle got %b want 100", n, {in_ready, busy, done});
         end
         repeat ($urandom_range(0, 2)) begin
            step();
            hold = 1'($urandom);
            #1;
            n_cmp++;
            if ({in_ready, busy, so_valid} !== 3'b100) begin
               n_err++; $display("FAIL rand_w%0d_gap got %b want 100", n, {in_ready, busy, so_valid});
            end
         end
         w = 8'($urandom);
         in_valid = 1'b1; in_data = w;
         step();
         j = 0; c = 0;
         while (j < W && c < 200) begin
            hold = ($urandom_range(0, 3) == 0);
            in_valid = 1'($urandom); in_data = 8'($urandom);
            #1;
            got = {so, so_valid, so_last, done};
            exp = {ref_bit(w, j, 1'b1), !hold, (!hold && j == W-1), 1'b0};
            n_cmp++;
            if (got !== exp) begin
               n_err++; $display("FAIL rand_w%0d_c%0d got %b want %b", n, c, got, exp);
            end
            if (!hold) j++;
            step();
            c++;
         end
         in_valid = 1'($urandom); hold = 1'($urandom);
         #1;
         n_cmp++;
         if ({done, so_valid, in_ready} !== 3'b100) begin
            n_err++; $display("FAIL rand_w%0d_done got %b want 100", n, {done, so_valid, in_ready});
         end
         step();
      end
      in_valid = 1'b0; hold = 1'b0;
   endtask

   initial begin
      test_reset();
      test_msb_first(8'hA5);
      test_lsb_first();
      test_hold();
      test_busy_reject();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
